emif_dfh_csr: RTL
=================

EMIF_DFH_CSR -- requirements
Module: emif_dfh_csr

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of EMIF channels (1..8).
REQ-002 SHALL have parameter DFH_VAL, default 64'h3_00000_00B000_1009, EMIF DFH contents (feat_id 12'h9).
REQ-003 SHALL have parameter CH_PRESENT, default {NUM_CH{1'b1}}, capability channel mask.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have AXI4-Lite write ports: awvalid in 1; awready out 1; awaddr in 12 byte address; wvalid in 1; wready out 1; wdata in 64; wstrb in 8; bvalid out 1; bready in 1; bresp out 2.
REQ-006 SHALL have AXI4-Lite read ports: arvalid in 1; arready out 1; araddr in 12; rvalid out 1; rready in 1; rdata out 64; rresp out 2.
REQ-007 SHALL have ports: cal_success in NUM_CH, cal_fail in NUM_CH (per-channel EMIF calibration status, asynchronous to clk).

Function
REQ-008 SHALL decode address bits [11:3]; bits [2:0] ignored; map 0x00 DFH (RO), 0x08 EMIF_STATUS (RO), 0x10 EMIF_CAPABILITY (RO), 0x18 SCRATCH (RW, see REQ-021).
REQ-009 SHALL return DFH_VAL at 0x00.
REQ-010 SHALL return at 0x08: [NUM_CH-1:0] synchronized cal_success, [8+NUM_CH-1:8] synchronized cal_fail, other bits 0.
REQ-011 SHALL pass cal_success and cal_fail each through a 2-flop synchronizer; status visible in a read issued 3 cycles after input change.
REQ-012 SHALL return at 0x10: [NUM_CH-1:0] CH_PRESENT, [19:16] NUM_CH, other bits 0.
REQ-013 SHALL return 0 with rresp OKAY for unmapped addresses; writes to RO/unmapped addresses ignored, bresp OKAY.
REQ-014 Read FSM SHALL have states RD_IDLE (arready=1) and RD_RESP (rvalid=1); AR handshake in RD_IDLE -> RD_RESP next cycle with rdata latched; rvalid&rready -> RD_IDLE.
REQ-015 rdata SHALL stay stable while rvalid=1 and rready=0; no new AR accepted in RD_RESP.
REQ-016 Write FSM SHALL have states WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP; awready=1 in WR_IDLE/WR_WAIT_AW, wready=1 in WR_IDLE/WR_WAIT_W.
REQ-017 WR_IDLE: AW+W same cycle -> WR_RESP; AW only -> WR_WAIT_W (addr latched); W only -> WR_WAIT_AW (data/strb latched); completing handshake -> WR_RESP.
REQ-018 Register update SHALL occur on the cycle entering WR_RESP, per-byte by wstrb; bvalid=1 in WR_RESP until bready, then WR_IDLE.
REQ-019 Read and write FSMs SHALL be independent; simultaneous read and write of the same register returns the pre-write value.
REQ-020 rresp and bresp SHALL always be 2'b00.

Configuration
REQ-021 With EMIF_CSR_SCRATCH_EN defined, 0x18 SHALL be a 64-bit RW scratch register reset to 0; without it, 0x18 SHALL read 0 and ignore writes.

Reset
REQ-022 On rst_n=0 at clk edge: both FSMs to IDLE, arready=awready=wready=0 during reset, rvalid=bvalid=0, rdata=0, synchronizers=0, scratch=0.
REQ-023 Reset mid-transaction SHALL abort it silently; no response issued after reset release; ready outputs assert the cycle after rst_n returns to 1.

Verification
REQ-024 Read 0x00 after reset -> rvalid 1 cycle after AR handshake, rdata=64'h3_00000_00B000_1009.
REQ-025 cal_success=4'hF, cal_fail=0 held 3 cycles, read 0x08 -> rdata=64'h0000_000F; then cal_fail[2]=1 -> rdata=64'h0000_040F.
REQ-026 Read 0x10 with defaults -> rdata=64'h0004_000F.
REQ-027 With macro: W before AW to 0x18, wdata=64'hDEAD_BEEF_0123_4567, wstrb=8'h0F -> bvalid once, read 0x18 = 64'h0000_0000_0123_4567; without macro read = 0.
REQ-028 rready held 0 for 5 cycles -> rdata stable, arready=0; write to 0x00 -> bresp OKAY, DFH unchanged.
REQ-029 Assert rst_n=0 in WR_WAIT_W -> bvalid never asserts; post-reset write completes normally.

Source files
------------

// File: rtl/emif_dfh_csr.sv
// EMIF device-feature-header CSR block: DFH, calibration status, capability and scratch over AXI4-Lite.
// Optional 64-bit scratch register at 0x18 is built only when EMIF_CSR_SCRATCH_EN is defined.
module emif_dfh_csr #(
    parameter int                NUM_CH     = 4,
    parameter logic [63:0]       DFH_VAL    = 64'h3_00000_00B000_1009,
    parameter logic [NUM_CH-1:0] CH_PRESENT = {NUM_CH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [11:0]       awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [11:0]       araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail
);

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_t;

    localparam logic [8:0] ADDR_DFH     = 9'h000;
    localparam logic [8:0] ADDR_STATUS  = 9'h001;
    localparam logic [8:0] ADDR_CAP     = 9'h002;
    localparam logic [8:0] ADDR_SCRATCH = 9'h003;

    rd_state_t         rd_state, rd_next;
    wr_state_t         wr_state, wr_next;
    logic              ready_en;
    logic [NUM_CH-1:0] succ_s1, succ_s2, fail_s1, fail_s2;
    logic [63:0]       status_word, cap_word, rd_mux, scratch_q;
    logic [8:0]        aw_lat, eff_addr;
    logic [63:0]       w_lat, eff_data;
    logic [7:0]        strb_lat, eff_strb;
    logic              do_write;

    assign rresp = 2'b00;
    assign bresp = 2'b00;

    // NOTE: readies come from a registered enable so they stay low throughout reset
    // and rise exactly one cycle after rst_n is released.
    always_ff @(posedge clk) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            succ_s1 <= '0;
            succ_s2 <= '0;
            fail_s1 <= '0;
            fail_s2 <= '0;
        end else begin
            succ_s1 <= cal_success;
            succ_s2 <= succ_s1;
            fail_s1 <= cal_fail;
            fail_s2 <= fail_s1;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        status_word              = '0;
        status_word[NUM_CH-1:0]  = succ_s2;
        status_word[8 +: NUM_CH] = fail_s2;
        cap_word                 = '0;
        cap_word[NUM_CH-1:0]     = CH_PRESENT;
        cap_word[19:16]          = 4'(NUM_CH);
    end

    always_comb begin
        case (araddr[11:3])
            ADDR_DFH:     rd_mux = DFH_VAL;
            ADDR_STATUS:  rd_mux = status_word;
            ADDR_CAP:     rd_mux = cap_word;
            ADDR_SCRATCH: rd_mux = scratch_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                arready = ready_en;
                if (arvalid && ready_en) rd_next = RD_RESP;
            end
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                    rdata <= '0;
        else if (arvalid && arready)   rdata <= rd_mux;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wr_state <= WR_IDLE;
        else        wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                awready = ready_en;
                wready  = ready_en;
                if (ready_en) begin
                    if (awvalid && wvalid) wr_next = WR_RESP;
                    else if (awvalid)      wr_next = WR_WAIT_W;
                    else if (wvalid)       wr_next = WR_WAIT_AW;
                end
            end
            WR_WAIT_W: begin
                wready = ready_en;
                if (wvalid && ready_en) wr_next = WR_RESP;
            end
            WR_WAIT_AW: begin
                awready = ready_en;
                if (awvalid && ready_en) wr_next = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // NOTE: holding registers carry no reset; they are only consumed after a handshake fills them.
    always_ff @(posedge clk) begin
        if (awvalid && awready) aw_lat <= awaddr[11:3];
        if (wvalid && wready) begin
            w_lat    <= wdata;
            strb_lat <= wstrb;
        end
    end

    // Whichever half arrived earlier comes from its holding register, the other from the bus.
    assign eff_addr = (wr_state == WR_WAIT_W)  ? aw_lat   : awaddr[11:3];
    assign eff_data = (wr_state == WR_WAIT_AW) ? w_lat    : wdata;
    assign eff_strb = (wr_state == WR_WAIT_AW) ? strb_lat : wstrb;
    assign do_write = (wr_state != WR_RESP) && (wr_next == WR_RESP);

`ifdef EMIF_CSR_SCRATCH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scratch_q <= '0;
        end else if (do_write && eff_addr == ADDR_SCRATCH) begin
            for (int b = 0; b < 8; b++) begin
                if (eff_strb[b]) scratch_q[8*b +: 8] <= eff_data[8*b +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{araddr[2:0], awaddr[2:0]};
`else
    assign scratch_q = '0;

    logic unused_bits;
    assign unused_bits = ^{araddr[2:0], awaddr[2:0], eff_addr, eff_data, eff_strb, do_write};
`endif

endmodule
